ws2812b_pulse_encoder: RTL
==========================

// Module: ws2812b_pulse_encoder
// PURPOSE
//   WS2812B transmitter: serialises 24-bit GRB pixels, MSB first (G7..G0, R7..R0, B7..B0), onto a single NRZ line.
//   Transmit-side counterpart of the pulse decoder / byte assembler chain.
//   One-pixel holding buffer gives gap-free back-to-back pixels.
//   Generates the strip latch (reset) low period after the last pixel or on underrun.
//   Sits behind the TinyQV peripheral register file and drives a uo_out pin.
// PARAMETERS
//   CLK_HZ        64000000  clock frequency, documentation/derivation only
//   T0H_CYCLES    26        high time of a '0' bit (0.40 us @ 64 MHz)
//   T1H_CYCLES    51        high time of a '1' bit (0.80 us @ 64 MHz)
//   BIT_CYCLES    80        full bit period (1.25 us @ 64 MHz)
//   LATCH_CYCLES  3840      low time closing a frame (60 us @ 64 MHz)
//   Legal values: 0 < T0H_CYCLES < T1H_CYCLES < BIT_CYCLES; LATCH_CYCLES >= 1.
//   Counter widths: $clog2 of the largest value + 1.
// PORTS
//   clk         in   1   system clock
//   reset       in   1   synchronous, active-high reset
//   pix_grb     in   24  pixel {G,R,B}; bit 23 is transmitted first
//   pix_last    in   1   pixel ends the frame; latch period follows it
//   pix_valid   in   1   pixel offered
//   pix_ready   out  1   holding buffer empty; accept = pix_valid & pix_ready at posedge
//   dout        out  1   WS2812B data line
//   busy        out  1   state != IDLE or holding buffer full
//   underrun    out  1   1-cycle pulse: pixel finished, not last, buffer empty
//   frame_done  out  1   1-cycle pulse in the final LATCH cycle
// BEHAVIOUR
//   - Reset: dout=0, pix_ready=1, busy=0, underrun=0, frame_done=0; state=IDLE; buffer empty; counters=0.
//     Reset mid-operation aborts the pixel; dout is 0 after the next edge; the buffered pixel is discarded.
//   - Buffer: one 25-bit register {last,grb} plus hold_full. pix_ready = !hold_full (registered flag).
//   - FSM: IDLE, SEND, LATCH.
//   - IDLE: if hold_full, the next edge moves the buffer to the shifter, clears hold_full, enters SEND, bit_cnt=0, cyc_cnt=0.
//     Latency: pixel accepted at edge N; dout rises at edge N+1.
//   - SEND: dout = (cyc_cnt < (shift[23] ? T1H_CYCLES : T0H_CYCLES)).
//     cyc_cnt counts 0..BIT_CYCLES-1; at BIT_CYCLES-1 it wraps to 0, shifts left 1, and bit_cnt++.
//   - End of pixel (bit_cnt=23, cyc_cnt=BIT_CYCLES-1), decided on that edge:
//       cur_last=1            -> LATCH.
//       else if hold_full     -> reload shifter from buffer and stay in SEND.
//                                The next bit's high phase starts immediately; no gap.
//       else                  -> LATCH and pulse underrun.
//     A pixel accepted on that same edge was not yet buffered: it counts as an underrun,
//     and it is sent after the latch.
//   - LATCH: dout=0 for LATCH_CYCLES cycles. frame_done=1 in the last one; then IDLE.
//     Pixels may be accepted during LATCH but are not sent until the state returns to IDLE.
//   - Simultaneous accept and buffer-to-shifter transfer on one edge cannot occur,
//     because pix_ready is 0 while hold_full=1.
//   - The buffer can be refilled on the edge after a transfer.
//   - dout, underrun and frame_done are registered outputs (glitch-free).
// CONFIGURATION
//   WS2812B_TX_INVERT_EN defined: dout is inverted at the output register, for an inverting level shifter.
//     Reset value and LATCH level of dout become 1.
//   Not defined: polarity as described above.
//   Nothing else changes.
// TESTING
//   1. Reset, then send 0x800001 with last=1.
//      -> dout high 51 cycles, low 29; next 22 bits 26 high / 54 low; final bit 51/29.
//      -> Then 3840 low, then frame_done pulse, then busy=0.
//   2. Send 3 pixels back-to-back (0xFF0000, 0x00FF00, 0x0000FF; last on the 3rd).
//      -> 5760 contiguous cycles of SEND with no extra low gap.
//      -> pix_ready returns to 1 one cycle after each reload.
//   3. Send 1 pixel with last=0 and no follow-up.
//      -> underrun pulses once at the end of bit 23; 3840-cycle latch; frame_done.
//   4. Offer the 2nd pixel exactly on the final edge of pixel 1.
//      -> underrun=1, latch, then the 2nd pixel is sent after frame_done.
//   5. Assert reset at bit 10 of a pixel.
//      -> dout=0 and pix_ready=1 the next cycle; no frame_done; a new pixel then sends cleanly.
//   6. Build with WS2812B_TX_INVERT_EN and repeat test 1.
//      -> dout is the exact bitwise complement; it idles at 1.

Source files
------------

// File: rtl/ws2812b_pulse_encoder.sv
// ---------------------------------------------------------------------------
// ws2812b_pulse_encoder
//
// Purpose:
//   WS2812B transmitter. Serialises 24-bit GRB pixels MSB first
//   (G7..G0, R7..R0, B7..B0) onto one NRZ data line. A one-pixel holding
//   buffer lets the next pixel follow the current one with no gap. After the
//   pixel flagged as last, or when the buffer runs dry mid-frame, the line is
//   held at its idle level for the latch period so the strip displays the frame.
//
// Ports:
//   clk         in   1   system clock
//   reset       in   1   synchronous, active-high reset
//   pix_grb     in   24  pixel {G,R,B}; bit 23 goes out first
//   pix_last    in   1   pixel closes the frame; the latch period follows it
//   pix_valid   in   1   pixel offered
//   pix_ready   out  1   holding buffer empty; accept = pix_valid & pix_ready
//   dout        out  1   WS2812B data line (registered)
//   busy        out  1   transmitting, latching, or a pixel is buffered
//   underrun    out  1   1-cycle pulse: non-last pixel ended with empty buffer
//   frame_done  out  1   1-cycle pulse during the final latch cycle
//
// Configuration macro:
//   WS2812B_TX_INVERT_EN  when defined, dout is inverted at its output
//                         register to drive an inverting level shifter; the
//                         line then resets and latches at 1.
// ---------------------------------------------------------------------------
module ws2812b_pulse_encoder #(
    parameter int CLK_HZ       = 64000000,
    parameter int T0H_CYCLES   = 26,
    parameter int T1H_CYCLES   = 51,
    parameter int BIT_CYCLES   = 80,
    parameter int LATCH_CYCLES = 3840
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] pix_grb,
    input  logic        pix_last,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        dout,
    output logic        busy,
    output logic        underrun,
    output logic        frame_done
);

    localparam int CYC_W = $clog2(BIT_CYCLES) + 1;
    localparam int LAT_W = $clog2(LATCH_CYCLES) + 1;

    localparam logic [CYC_W-1:0] T0H_C      = CYC_W'(T0H_CYCLES);
    localparam logic [CYC_W-1:0] T1H_C      = CYC_W'(T1H_CYCLES);
    localparam logic [CYC_W-1:0] BIT_LAST_C = CYC_W'(BIT_CYCLES - 1);
    localparam logic [LAT_W-1:0] LAT_LAST_C = LAT_W'(LATCH_CYCLES - 1);

`ifdef WS2812B_TX_INVERT_EN
    localparam logic DOUT_INV = 1'b1;
`else
    localparam logic DOUT_INV = 1'b0;
`endif

    // Refuse to elaborate with timing values that cannot form a valid bit.
    if (!(CLK_HZ > 0 && T0H_CYCLES > 0 && T0H_CYCLES < T1H_CYCLES &&
          T1H_CYCLES < BIT_CYCLES && LATCH_CYCLES >= 1)) begin : g_bad_params
        $error("ws2812b_pulse_encoder: illegal timing parameters");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    state_t             state_q,      state_d;
    logic [24:0]        hold_q,       hold_d;
    logic               hold_full_q,  hold_full_d;
    logic [23:0]        shift_q,      shift_d;
    logic               cur_last_q,   cur_last_d;
    logic [4:0]         bit_cnt_q,    bit_cnt_d;
    logic [CYC_W-1:0]   cyc_cnt_q,    cyc_cnt_d;
    logic [LAT_W-1:0]   lat_cnt_q,    lat_cnt_d;
    logic               underrun_q,   underrun_d;
    logic               frame_done_q, frame_done_d;
    logic               dout_q,       dout_d;
    logic [CYC_W-1:0]   high_lim;
    logic               accept;

    // Accept only into an empty buffer. A transfer out of the buffer only
    // happens while it is full, so accept and transfer never share an edge.
    assign accept = pix_valid & ~hold_full_q;

    // Next-state logic. The registered outputs are derived from the *next*
    // state so that dout, underrun and frame_done line up with the state the
    // FSM is in during the cycle they are visible.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        shift_d      = shift_q;
        cur_last_d   = cur_last_q;
        bit_cnt_d    = bit_cnt_q;
        cyc_cnt_d    = cyc_cnt_q;
        lat_cnt_d    = lat_cnt_q;
        underrun_d   = 1'b0;
        frame_done_d = 1'b0;
        dout_d       = 1'b0;
        high_lim     = T0H_C;

        case (state_q)
            ST_IDLE: begin
                if (hold_full_q) begin
                    shift_d     = hold_q[23:0];
                    cur_last_d  = hold_q[24];
                    hold_full_d = 1'b0;
                    bit_cnt_d   = 5'd0;
                    cyc_cnt_d   = '0;
                    state_d     = ST_SEND;
                end
            end

            ST_SEND: begin
                if (cyc_cnt_q == BIT_LAST_C) begin
                    cyc_cnt_d = '0;
                    if (bit_cnt_q == 5'd23) begin
                        // Pixel boundary: close the frame, chain the buffered
                        // pixel without a gap, or fall into latch as underrun.
                        bit_cnt_d = 5'd0;
                        if (cur_last_q) begin
                            lat_cnt_d = '0;
                            state_d   = ST_LATCH;
                        end else if (hold_full_q) begin
                            shift_d     = hold_q[23:0];
                            cur_last_d  = hold_q[24];
                            hold_full_d = 1'b0;
                        end else begin
                            lat_cnt_d  = '0;
                            underrun_d = 1'b1;
                            state_d    = ST_LATCH;
                        end
                    end else begin
                        shift_d   = {shift_q[22:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end else begin
                    cyc_cnt_d = cyc_cnt_q + {{(CYC_W-1){1'b0}}, 1'b1};
                end
            end

            ST_LATCH: begin
                if (lat_cnt_q == LAT_LAST_C) begin
                    lat_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q + {{(LAT_W-1){1'b0}}, 1'b1};
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            hold_d      = {pix_last, pix_grb};
            hold_full_d = 1'b1;
        end

        high_lim     = shift_d[23] ? T1H_C : T0H_C;
        dout_d       = (state_d == ST_SEND) && (cyc_cnt_d < high_lim);
        frame_done_d = (state_d == ST_LATCH) && (lat_cnt_d == LAT_LAST_C);
    end

    // State and output registers. Reset abandons any pixel in flight and
    // discards the buffered one; the line returns to its idle level.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            shift_q      <= '0;
            cur_last_q   <= 1'b0;
            bit_cnt_q    <= 5'd0;
            cyc_cnt_q    <= '0;
            lat_cnt_q    <= '0;
            underrun_q   <= 1'b0;
            frame_done_q <= 1'b0;
            dout_q       <= DOUT_INV;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            shift_q      <= shift_d;
            cur_last_q   <= cur_last_d;
            bit_cnt_q    <= bit_cnt_d;
            cyc_cnt_q    <= cyc_cnt_d;
            lat_cnt_q    <= lat_cnt_d;
            underrun_q   <= underrun_d;
            frame_done_q <= frame_done_d;
            dout_q       <= dout_d ^ DOUT_INV;
        end
    end

    assign pix_ready  = ~hold_full_q;
    assign busy       = (state_q != ST_IDLE) || hold_full_q;
    assign dout       = dout_q;
    assign underrun   = underrun_q;
    assign frame_done = frame_done_q;

endmodule
